// File: rtl/sb_deserializer.sv
// sb_deserializer
//   Sideband receive-path deserializer. Samples the synchronized serial line
//   once per clk and reassembles WIDTH-bit symbols (start bit, data, stop
//   bit, LSB first). Also reports the line state to the sideband link FSM.
//
// Ports
//   clk               in   sideband bit clock, one sample per rising edge
//   rst               in   asynchronous reset, active-low
//   ser_in            in   serial line, already synchronized to clk
//   parallel_out      out  last completed symbol, bit 0 = first bit received
//   data_valid        out  1-cycle pulse, parallel_out holds a good symbol
//   framing_err       out  1-cycle pulse, a symbol ended with stop bit = 0
//   line_idle         out  high while in IDLE
//   line_disconnected out  high while in DISC
module sb_deserializer #(
  parameter int WIDTH       = 10,
  parameter int DISC_CYCLES = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  output logic [WIDTH-1:0] parallel_out,
  output logic             data_valid,
  output logic             framing_err,
  output logic             line_idle,
  output logic             line_disconnected
);

  localparam int CW = $clog2(WIDTH);
  localparam int ZW = $clog2(DISC_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_DISC,
    ST_IDLE,
    ST_RECV,
    ST_HUNT
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-2:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ZW-1:0]    zrun_q, zrun_d;
  logic [WIDTH-1:0] parallel_out_q, parallel_out_d;
  logic             data_valid_q, data_valid_d;
  logic             framing_err_q, framing_err_d;
  logic             line_idle_q, line_idle_d;
  logic             line_disconnected_q, line_disconnected_d;

  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    cnt_d          = cnt_q;
    parallel_out_d = parallel_out_q;
    data_valid_d   = 1'b0;
    framing_err_d  = 1'b0;

    if (ser_in) begin
      zrun_d = '0;
    end else if (zrun_q == ZW'(DISC_CYCLES)) begin
      zrun_d = zrun_q;
    end else begin
      zrun_d = zrun_q + ZW'(1);
    end

    unique case (state_q)
      ST_DISC: begin
        if (ser_in) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!ser_in) begin
          state_d    = ST_RECV;
          shift_d[0] = ser_in;
          cnt_d      = CW'(1);
        end
      end
      ST_RECV: begin
        if (cnt_q == '0) begin
          // Counter 0 in RECV follows a good stop bit: apply the IDLE rules
          // without reporting idle, so back-to-back frames need no gap.
          if (ser_in) begin
            state_d = ST_IDLE;
          end else begin
            shift_d[0] = ser_in;
            cnt_d      = CW'(1);
          end
        end else if (cnt_q == CW'(WIDTH - 1)) begin
          parallel_out_d = {ser_in, shift_q};
          cnt_d          = '0;
          if (ser_in) begin
            data_valid_d = 1'b1;
          end else begin
            framing_err_d = 1'b1;
            state_d       = ST_HUNT;
          end
        end else begin
          for (int unsigned i = 1; i < WIDTH - 1; i++) begin
            if (cnt_q == CW'(i)) shift_d[i] = ser_in;
          end
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HUNT: begin
        if (ser_in) state_d = ST_IDLE;
      end
      default: state_d = ST_DISC;
    endcase

    // A long zero run overrides everything; any partial frame is dropped.
    if (zrun_d == ZW'(DISC_CYCLES)) begin
      state_d        = ST_DISC;
      cnt_d          = '0;
      parallel_out_d = parallel_out_q;
      data_valid_d   = 1'b0;
      framing_err_d  = 1'b0;
    end

    line_idle_d         = (state_d == ST_IDLE);
    line_disconnected_d = (state_d == ST_DISC);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q             <= ST_DISC;
      shift_q             <= '0;
      cnt_q               <= '0;
      zrun_q              <= '0;
      parallel_out_q      <= '0;
      data_valid_q        <= 1'b0;
      framing_err_q       <= 1'b0;
      line_idle_q         <= 1'b0;
      line_disconnected_q <= 1'b1;
    end else begin
      state_q             <= state_d;
      shift_q             <= shift_d;
      cnt_q               <= cnt_d;
      zrun_q              <= zrun_d;
      parallel_out_q      <= parallel_out_d;
      data_valid_q        <= data_valid_d;
      framing_err_q       <= framing_err_d;
      line_idle_q         <= line_idle_d;
      line_disconnected_q <= line_disconnected_d;
    end
  end

  assign parallel_out      = parallel_out_q;
  assign data_valid        = data_valid_q;
  assign framing_err       = framing_err_q;
  assign line_idle         = line_idle_q;
  assign line_disconnected = line_disconnected_q;

endmodule
